ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
// - Shares the single 256x16 RAM between two requesters: CPU port (MAR/MBR path driven by cu) and DBG port (program loader/debug).
// - Sequences each access as issue -> wait RAM latency -> ack.
// - Returns registered read data per port.
// - Sits between MBR/MAR and RAM. Replaces the direct control_signal-driven RAM enable.
// PARAMETERS
// - ADDR_W        8   RAM address width
// - DATA_W        16  RAM data width
// - RAM_LAT       1   cycles from ram_en to valid ram_rdata (>=1)
// - CPU_PRIORITY  0   0 = round-robin; 1 = CPU fixed priority with starvation guard
// - STARVE_LIMIT  4   fixed-priority mode: consecutive DBG losses before DBG is forced to win
// PORTS
// - clk        in   1       clock, rising edge
// - rst        in   1       synchronous reset, active-low
// - cpu_req    in   1       CPU access request; held with cmd stable until cpu_ack
// - cpu_we     in   1       1 = write, 0 = read
// - cpu_addr   in   ADDR_W  CPU address
// - cpu_wdata  in   DATA_W  CPU write data
// - cpu_ack    out  1       one-cycle completion pulse
// - cpu_rdata  out  DATA_W  read data; valid with cpu_ack, held until the next CPU read ack
// - dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_ack / dbg_rdata: same as the CPU set, for the DBG port
// - ram_en     out  1       RAM access strobe, one cycle per transaction
// - ram_we     out  1       RAM write enable, qualified by ram_en
// - ram_addr   out  ADDR_W  RAM address
// - ram_wdata  out  DATA_W  RAM write data
// - ram_rdata  in   DATA_W  RAM read data, valid RAM_LAT cycles after ram_en
// - owner      out  2       00 none, 01 CPU, 10 DBG; current transaction owner
// - busy       out  1       1 when state != IDLE
// BEHAVIOUR
// - Reset (rst==0 at a clk edge): state=IDLE, owner=00.
//   - All acks, ram_en, ram_we = 0; ram_addr, ram_wdata, both rdata = 0.
//   - last_served=DBG (so CPU wins the first contention); starve_cnt=0.
// - FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//   - IDLE: if any req, arbitrate, latch owner/we/addr/wdata, go to ISSUE; else stay.
//   - ISSUE (1 cycle): ram_en=1, ram_we=latched we; addr/wdata from latched cmd; load wait_cnt=RAM_LAT-1.
//   - WAIT: decrement wait_cnt. When 0, capture ram_rdata into owner's rdata (reads only) and go to ACK.
//   - ACK (1 cycle): owner's ack=1; go to IDLE. owner returns to 00 in IDLE.
// - Latency: req sampled in IDLE at cycle N -> ram_en at N+1 -> ack at N+2+RAM_LAT (N+3 at default).
//   - Writes use identical timing. No back-to-back issue; each transaction holds the RAM 3+RAM_LAT cycles.
// - Handshake:
//   - Requester deasserts req, or presents a new command, in the cycle after ack.
//   - req still high in IDLE after ack is a new transaction.
//   - req dropped before ack: the transaction still completes and ack still pulses (no abort).
// - Arbitration (IDLE only; the command is latched, so later input changes are ignored):
//   - Single requester: it wins.
//   - Round-robin (CPU_PRIORITY=0), both requesting: the port not equal to last_served wins; last_served updates on grant.
//   - Fixed priority (CPU_PRIORITY=1), both requesting: CPU wins and starve_cnt++.
//     - If starve_cnt==STARVE_LIMIT, DBG wins instead and starve_cnt clears.
//     - starve_cnt also clears on any DBG grant and whenever dbg_req==0 in IDLE.
// - Reads: the non-owner rdata is unchanged. Writes: rdata is unchanged.
// - Reset mid-operation: FSM aborts to IDLE and no ack is issued.
//   - If reset coincides with the ISSUE cycle, the RAM still sees that ram_en edge; a write may land. Bench must tolerate this.
// - Width rules: no arithmetic on data; wait_cnt width = clog2(RAM_LAT)+1; starve_cnt width = clog2(STARVE_LIMIT+1).
// STRUCTURE
// - Shared package cpu_pkg: FSM state encoding (IDLE/ISSUE/WAIT/ACK), OWNER_NONE/CPU/DBG codes, ADDR_W/DATA_W defaults.
// - One sub-module arb2_rr: combinational 2-way winner select plus the registered last_served and starve_cnt.
//   - Inputs: req pair and mode. Outputs: grant one-hot. Update strobe from the FSM.
// - Top holds the FSM, command latch, wait counter and rdata/ack registers.
// TESTING
// 1. Reset: hold rst=0 for 3 clk with reqs high -> no ram_en, acks 0, owner=00, busy=0, rdata=0.
// 2. CPU write 8'hA1<=16'h1234, then CPU read 8'hA1:
//    - write: ram_en/ram_we at N+1, cpu_ack at N+3.
//    - read: cpu_ack at N+3 of the read with cpu_rdata=16'h1234.
// 3. Round-robin, both req held continuously with distinct addrs -> grants alternate CPU, DBG, CPU, DBG; each ack 4 cycles apart.
// 4. CPU_PRIORITY=1, STARVE_LIMIT=4, both req held -> 4 CPU grants, then 1 DBG grant, then repeat; starve_cnt resets after the DBG grant.
// 5. RAM_LAT=3: DBG read -> ram_en at N+1, dbg_ack at N+5; cpu_rdata unchanged.
// 6. Abort/violation:
//    - rst=0 during WAIT -> no ack, state IDLE next cycle.
//    - cpu_req dropped during WAIT -> cpu_ack still pulses.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM arbiter slice.
// Holds the arbiter FSM state encoding, the owner codes reported on the
// owner port, and the default RAM geometry (256 x 16).
package cpu_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_t;

   // Owner codes double as the one-hot grant vector: bit 0 = CPU, bit 1 = DBG.
   localparam logic [1:0] OWNER_NONE = 2'b00;
   localparam logic [1:0] OWNER_CPU  = 2'b01;
   localparam logic [1:0] OWNER_DBG  = 2'b10;

endpackage

// File: rtl/arb2_rr.sv
// Two-way winner select between the CPU and DBG requesters.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   cpu_req,dbg_req request pair
//   mode            0 = round-robin, 1 = CPU fixed priority with starvation guard
//   arb_en          high while the FSM is idle; grants and history update only then
//   grant           one-hot winner (bit 0 CPU, bit 1 DBG), 00 when nobody asks
module arb2_rr
   import cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_req,
   input  logic       dbg_req,
   input  logic       mode,
   input  logic       arb_en,
   output logic [1:0] grant
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

   logic          last_dbg;
   logic [SW-1:0] starve_cnt;

   // Pick the winner. Contention is the only interesting case: round-robin
   // favours whoever was not served last, fixed priority favours the CPU
   // unless DBG has already lost LIMIT times in a row.
   always_comb begin
      grant = OWNER_NONE;
      if (cpu_req && dbg_req) begin
         if (!mode) begin
            grant = last_dbg ? OWNER_CPU : OWNER_DBG;
         end else begin
            grant = (starve_cnt == LIMIT) ? OWNER_DBG : OWNER_CPU;
         end
      end else if (cpu_req) begin
         grant = OWNER_CPU;
      end else if (dbg_req) begin
         grant = OWNER_DBG;
      end
   end

   // History kept across transactions. last_dbg starts set so the CPU wins
   // the first contention. The starvation count only grows while DBG is
   // actively losing; any DBG win or any idle cycle without a DBG request
   // clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_dbg   <= 1'b1;
         starve_cnt <= '0;
      end else if (arb_en) begin
         if (grant != OWNER_NONE) begin
            last_dbg <= grant[1];
         end
         if (!dbg_req || grant[1]) begin
            starve_cnt <= '0;
         end else if (mode) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between the CPU (MAR/MBR path) and the DBG
// loader. Every access runs IDLE -> ISSUE -> WAIT -> ACK, holding the RAM
// for 3 + RAM_LAT cycles, and read data is returned in a per-port register.
// Ports:
//   clk, rst                     clock (rising edge), synchronous active-low reset
//   cpu_req/we/addr/wdata        CPU command, held stable until cpu_ack
//   cpu_ack, cpu_rdata           one-cycle completion pulse, held read data
//   dbg_req/we/addr/wdata        DBG command, same protocol as the CPU
//   dbg_ack, dbg_rdata           DBG completion pulse and held read data
//   ram_en, ram_we               one-cycle access strobe and qualified write enable
//   ram_addr, ram_wdata          address and write data toward the RAM
//   ram_rdata                    RAM read data, valid RAM_LAT cycles after ram_en
//   owner                        00 none, 01 CPU, 10 DBG
//   busy                         high whenever the FSM is not idle
module ram_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int RAM_LAT      = 1,
   parameter int CPU_PRIORITY = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        owner,
   output logic              busy
);

   localparam int WW = $clog2(RAM_LAT) + 1;
   localparam logic [WW-1:0] WAIT_INIT = WW'(RAM_LAT - 1);

   arb_state_t    state;
   logic          cmd_we;
   logic [WW-1:0] wait_cnt;
   logic [1:0]    grant;

   arb2_rr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .cpu_req(cpu_req),
      .dbg_req(dbg_req),
      .mode   (CPU_PRIORITY != 0),
      .arb_en (state == ST_IDLE),
      .grant  (grant)
   );

   assign busy = (state != ST_IDLE);

   // Transaction sequencer. The winning command is copied straight into the
   // RAM-facing address/data registers at grant time, so later changes on
   // the request ports cannot disturb an access in flight. Strobes and acks
   // default low every cycle so each one is a single-cycle pulse. Read data
   // is captured on the last WAIT cycle so it appears together with the ack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         owner     <= OWNER_NONE;
         cmd_we    <= 1'b0;
         wait_cnt  <= '0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         ram_en  <= 1'b0;
         ram_we  <= 1'b0;
         case (state)
            ST_IDLE: begin
               // grant is already in owner encoding (00 when nobody asks)
               owner <= grant;
               if (grant == OWNER_CPU) begin
                  cmd_we    <= cpu_we;
                  ram_we    <= cpu_we;
                  ram_addr  <= cpu_addr;
                  ram_wdata <= cpu_wdata;
               end else if (grant == OWNER_DBG) begin
                  cmd_we    <= dbg_we;
                  ram_we    <= dbg_we;
                  ram_addr  <= dbg_addr;
                  ram_wdata <= dbg_wdata;
               end
               if (grant != OWNER_NONE) begin
                  ram_en <= 1'b1;
                  state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               wait_cnt <= WAIT_INIT;
               state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  if (!cmd_we) begin
                     if (owner == OWNER_CPU) begin
                        cpu_rdata <= ram_rdata;
                     end else begin
                        dbg_rdata <= ram_rdata;
                     end
                  end
                  cpu_ack <= (owner == OWNER_CPU);
                  dbg_ack <= (owner == OWNER_DBG);
                  state   <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            ST_ACK: begin
               owner <= OWNER_NONE;
               state <= ST_IDLE;
            end
            default: begin
               owner <= OWNER_NONE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
